// File: rtl/popcount_pipe.sv
// Pipelined population counter: per-chunk leaf popcounts feed a registered pairwise adder tree.
// A valid/ready handshake with a global stall holds every stage under downstream backpressure.
module popcount_pipe #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CHUNK = 4
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       mode_i,
  input  logic                       data_val_i,
  output logic                       data_rdy_o,
  output logic [$clog2(WIDTH+1)-1:0] data_o,
  output logic                       data_val_o,
  input  logic                       data_rdy_i
);

  // Guarded so an illegal CHUNK still elaborates far enough to report the error below.
  localparam int unsigned CHUNK_S = (CHUNK < 1) ? 1 : CHUNK;
  localparam int unsigned NCHUNK  = (WIDTH + CHUNK_S - 1) / CHUNK_S;
  localparam int unsigned LAT     = 1 + $clog2(NCHUNK);
  localparam int unsigned CW      = $clog2(WIDTH + 1);
  localparam int unsigned PW      = NCHUNK * CHUNK_S;

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
    $error("popcount_pipe: CHUNK (%0d) must be in 1..WIDTH (%0d)", CHUNK, WIDTH);
  end

  // Number of live sums at a given tree level.
  function automatic int unsigned level_count(input int unsigned lvl);
    int unsigned n;
    n = NCHUNK;
    for (int unsigned i = 0; i < lvl; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  logic [PW-1:0]  padded;
  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] in_val;
  logic           stall;

  // Every level is held at CW bits; a level's real sum width never exceeds CW since the
  // largest possible total is WIDTH.
  logic [CW-1:0] sum_d [LAT][NCHUNK];
  logic [CW-1:0] sum_q [LAT][NCHUNK];

  assign stall      = valid_q[LAT-1] && !data_rdy_i;
  assign data_rdy_o = !stall;
  assign data_val_o = valid_q[LAT-1];
  assign data_o     = sum_q[LAT-1][0];

  // Pad bits stay zero in both modes so they never contribute to the count.
  always_comb begin
    padded            = '0;
    padded[WIDTH-1:0] = mode_i ? ~data_i : data_i;
  end

  for (genvar j = 0; j < NCHUNK; j++) begin : g_leaf
    logic [CW-1:0] leaf;
    always_comb begin
      leaf = '0;
      for (int unsigned b = 0; b < CHUNK_S; b++) begin
        leaf = leaf + CW'(padded[j*CHUNK_S + b]);
      end
    end
    assign sum_d[0][j] = leaf;
  end

  for (genvar s = 1; s < LAT; s++) begin : g_lvl
    localparam int unsigned NIN = level_count(s - 1);
    for (genvar j = 0; j < NCHUNK; j++) begin : g_node
      if (2*j + 1 < NIN) begin : g_add
        assign sum_d[s][j] = sum_q[s-1][2*j] + sum_q[s-1][2*j+1];
      end else if (2*j < NIN) begin : g_pass
        assign sum_d[s][j] = sum_q[s-1][2*j];
      end else begin : g_zero
        assign sum_d[s][j] = '0;
      end
    end
  end

  // Valid entering each stage; a stage's sums only load when a real word arrives, which
  // keeps data_o at the last result while bubbles pass through.
  always_comb begin
    in_val    = '0;
    in_val[0] = data_val_i;
    for (int unsigned s = 1; s < LAT; s++) begin
      in_val[s] = valid_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        for (int unsigned j = 0; j < NCHUNK; j++) begin
          sum_q[s][j] <= '0;
        end
      end
    end else if (!stall) begin
      valid_q <= in_val;
      for (int unsigned s = 0; s < LAT; s++) begin
        if (in_val[s]) begin
          for (int unsigned j = 0; j < NCHUNK; j++) begin
            sum_q[s][j] <= sum_d[s][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: boundary-vector table, stream/backpressure/reset sequences and a
// randomized scoreboard run against a count-of-ones reference model.
module tb_popcount_pipe;

  parameter int unsigned WIDTH = 12;
  parameter int unsigned CHUNK = 4;

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned LAT    = 1 + $clog2(NCHUNK);
  localparam int unsigned CW     = $clog2(WIDTH + 1);
  localparam int          NRAND  = 3000;

  logic             clk;
  logic             srst;
  logic [WIDTH-1:0] data_in;
  logic             mode;
  logic             val_in;
  logic             rdy_out;
  logic [CW-1:0]    data_out;
  logic             val_out;
  logic             rdy_in;

  int n_vec;
  int n_err;

  popcount_pipe #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk_i     (clk),
    .srst_i    (srst),
    .data_i    (data_in),
    .mode_i    (mode),
    .data_val_i(val_in),
    .data_rdy_o(rdy_out),
    .data_o    (data_out),
    .data_val_o(val_out),
    .data_rdy_i(rdy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             mode;
    int unsigned      expect_cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int unsigned ref_count(input logic [WIDTH-1:0] d, input logic m);
    int unsigned ones;
    ones = $countones(d);
    return m ? WIDTH - ones : ones;
  endfunction

  // Send one word into an idle pipe and measure how many cycles until it appears.
  task automatic single_word(input string name, input logic [WIDTH-1:0] d, input logic m,
                             input int unsigned exp);
    int lat;
    lat = 0;
    data_in = d;
    mode    = m;
    val_in  = 1'b1;
    rdy_in  = 1'b1;
    tick();
    val_in = 1'b0;
    for (int k = 1; k <= int'(LAT) + 2 && lat == 0; k++) begin
      if (k > 1) tick();
      settle();
      if (val_out) lat = k;
    end
    check({name, "_latency"}, lat, LAT);
    check({name, "_data"}, data_out, exp);
    tick();
    check({name, "_single_valid"}, val_out, 0);
  endtask

  // Words with 1..WIDTH low ones on consecutive cycles, optional downstream stall window.
  task automatic run_stream(input string tag, input int stall_at, input int stall_len);
    logic [WIDTH-1:0] ones;
    logic [CW-1:0]    got[$];
    logic [CW-1:0]    held;
    logic             held_v;
    logic             fire_in;
    int               idx;
    int               cyc;
    int               first;
    ones   = '1;
    idx    = 0;
    cyc    = 0;
    first  = -1;
    held   = '0;
    held_v = 1'b0;
    while (got.size() < WIDTH && cyc < 200) begin
      val_in  = (idx < int'(WIDTH));
      data_in = ones >> (WIDTH - 1 - ((idx < int'(WIDTH)) ? idx : WIDTH - 1));
      mode    = 1'b0;
      rdy_in  = !(cyc >= stall_at && cyc < stall_at + stall_len);
      settle();
      if (val_out && !rdy_in) begin
        check({tag, "_rdy_o_low_on_stall"}, rdy_out, 0);
        if (held_v) check({tag, "_hold"}, data_out, held);
        held   = data_out;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      fire_in = val_in && rdy_out;
      if (val_out && rdy_in) begin
        if (first < 0) first = cyc;
        got.push_back(data_out);
      end
      tick();
      if (fire_in) idx++;
      cyc++;
    end
    val_in = 1'b0;
    rdy_in = 1'b1;
    check({tag, "_count"}, got.size(), WIDTH);
    check({tag, "_first_latency"}, first, LAT);
    for (int i = 0; i < got.size(); i++) begin
      check({tag, "_seq"}, got[i], i + 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] d;
    logic             m;
    logic [CW-1:0]    held;
    logic             held_v;
    int               exp_q[$];
    int               sent;
    int               cyc;
    int               lat;

    n_vec   = 0;
    n_err   = 0;
    srst    = 1'b1;
    data_in = '0;
    mode    = 1'b0;
    val_in  = 1'b0;
    rdy_in  = 1'b1;

    tbl[0] = '{data: '1,                 mode: 1'b0, expect_cnt: WIDTH};
    tbl[1] = '{data: '0,                 mode: 1'b1, expect_cnt: WIDTH};
    tbl[2] = '{data: '0,                 mode: 1'b0, expect_cnt: 0};
    tbl[3] = '{data: '1,                 mode: 1'b1, expect_cnt: 0};
    tbl[4] = '{data: WIDTH'(12'hA5A),    mode: 1'b0, expect_cnt: 6};
    tbl[5] = '{data: WIDTH'(12'hA5A),    mode: 1'b1, expect_cnt: 6};
    tbl[6] = '{data: WIDTH'(1),          mode: 1'b1, expect_cnt: WIDTH - 1};
    tbl[7] = '{data: WIDTH'(1),          mode: 1'b0, expect_cnt: 1};
    tbl[8] = '{data: WIDTH'(12'h0F0),    mode: 1'b0, expect_cnt: 4};

    // Reset held three cycles, then one clean cycle after release.
    repeat (3) tick();
    check("reset_val_o", val_out, 0);
    check("reset_data_o", data_out, 0);
    check("reset_rdy_o", rdy_out, 1);
    srst = 1'b0;
    tick();
    check("post_reset_val_o", val_out, 0);
    check("post_reset_data_o", data_out, 0);
    check("post_reset_rdy_o", rdy_out, 1);

    for (int i = 0; i < 9; i++) begin
      single_word($sformatf("vec%0d", i), tbl[i].data, tbl[i].mode, tbl[i].expect_cnt);
    end

    run_stream("stream", 1000, 0);
    run_stream("backpressure", 4, 5);

    // Reset with words in flight: none of them may ever emerge.
    rdy_in = 1'b1;
    val_in = 1'b1;
    mode   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = WIDTH'($urandom);
      tick();
    end
    srst    = 1'b1;
    data_in = '1;
    tick();
    srst   = 1'b0;
    val_in = 1'b0;
    settle();
    check("flush_data_o", data_out, 0);
    check("flush_rdy_o", rdy_out, 1);
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      check("flush_val_o", val_out, 0);
      tick();
    end
    d = WIDTH'($urandom);
    m = 1'(($urandom));
    single_word("post_flush", d, m, ref_count(d, m));

    // Random traffic on both sides against the scoreboard.
    sent   = 0;
    cyc    = 0;
    held   = '0;
    held_v = 1'b0;
    while ((sent < NRAND || exp_q.size() > 0) && cyc < 40000) begin
      val_in  = (sent < NRAND) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_in = WIDTH'($urandom);
      mode    = 1'($urandom_range(0, 1));
      rdy_in  = 1'($urandom_range(0, 1));
      settle();
      check("rand_rdy_o", rdy_out, !(val_out && !rdy_in));
      if (val_out && !rdy_in) begin
        if (held_v) check("rand_hold", data_out, held);
        held   = data_out;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (val_out && rdy_in) begin
        if (exp_q.size() == 0) check("rand_spurious", val_out, 0);
        else check("rand_data", data_out, exp_q.pop_front());
      end
      if (val_in && rdy_out) begin
        exp_q.push_back(int'(ref_count(data_in, mode)));
        sent++;
      end
      tick();
      cyc++;
    end
    val_in = 1'b0;
    check("rand_sent", sent, NRAND);
    check("rand_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
